// File: rtl/dcdiff_pkg.sv
`default_nettype none
//============================================================================
// Module   : dcdiff_pkg
// Purpose  : Shared types and table constants for the DC-difference decoder.
// Revision : 1.0 - initial release
//============================================================================
package dcdiff_pkg;

    typedef enum logic [1:0] {
        S_CODE  = 2'd0,
        S_EXTRA = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    typedef enum logic {
        LUMA   = 1'b0,
        CHROMA = 1'b1
    } tsel_t;

    localparam int c_MAX_SIZE         = 11;
    localparam int c_LUMA_MAX_ONES    = 8;
    localparam int c_CHROMA_MAX_ONES  = 10;
    // Size of a long code is (leading ones) + offset.
    localparam int c_LUMA_LONG_OFS    = 3;
    localparam int c_CHROMA_LONG_OFS  = 1;

endpackage
`default_nettype wire

// File: rtl/dcdiff_hdecode_if.sv
`default_nettype none
//============================================================================
// Module   : dcdiff_hdecode_if
// Purpose  : Bit-input and result-output handshakes of the DC-diff decoder.
// Revision : 1.0 - initial release
//============================================================================
interface dcdiff_hdecode_if #(
    parameter int DIFF_W = 12
);
    logic              lumenb;
    logic              chromenb_u;
    logic              chromenb_v;
    logic              bit_in;
    logic              bit_valid;
    logic              bit_ready;
    logic [3:0]        size;
    logic [DIFF_W-1:0] diff;
    logic              err;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  lumenb, chromenb_u, chromenb_v, bit_in, bit_valid, out_ready,
        output bit_ready, size, diff, err, out_valid
    );

    modport master (
        output lumenb, chromenb_u, chromenb_v, bit_in, bit_valid, out_ready,
        input  bit_ready, size, diff, err, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/dcdiff_extend.sv
`default_nettype none
//============================================================================
// Module   : dcdiff_extend
// Purpose  : JPEG magnitude extension of (size, mag) to a signed difference.
// Revision : 1.0 - initial release
//============================================================================
module dcdiff_extend #(
    parameter int DIFF_W   = 12,
    parameter int MAX_SIZE = 11
) (
    input  wire logic [3:0]          size,
    input  wire logic [MAX_SIZE-1:0] mag,
    output logic      [DIFF_W-1:0]   diff
);
    logic [DIFF_W-1:0] w_mag;
    logic [DIFF_W-1:0] w_mask;
    logic              w_top;

    always_comb begin
        w_mag  = DIFF_W'(mag);
        w_mask = (DIFF_W'(1) << size) - DIFF_W'(1);
        w_top  = |(w_mag & (DIFF_W'(1) << (size - 4'd1)));
        diff   = '0;
        if (size != 4'd0) begin
            // Leading zero means negative: value is mag - (2^size - 1).
            diff = w_top ? (w_mag & w_mask) : ((w_mag & w_mask) - w_mask);
        end
    end
endmodule
`default_nettype wire

// File: rtl/dcdiff_hdecode.sv
`default_nettype none
//============================================================================
// Module   : dcdiff_hdecode
// Purpose  : Serial JPEG DC-difference Huffman decoder, one bit per cycle.
// Revision : 1.0 - initial release
//============================================================================
module dcdiff_hdecode
    import dcdiff_pkg::*;
#(
    parameter int DIFF_W   = 12,
    parameter int MAX_SIZE = c_MAX_SIZE
) (
    input  wire logic       clk,
    input  wire logic       rst,
    dcdiff_hdecode_if.slave bus
);
    state_t                r_state, w_state_nxt;
    tsel_t                 r_tsel, w_tsel_nxt, w_tsel;
    logic [3:0]            r_len, w_len_nxt;
    logic                  r_allones, w_allones_nxt;
    logic [1:0]            r_code, w_code_nxt;
    logic [3:0]            r_ext, w_ext_nxt;
    logic [MAX_SIZE-1:0]   r_mag, w_mag_nxt, w_mag_shift;
    logic [3:0]            r_size, w_size_nxt;
    logic [DIFF_W-1:0]     r_diff, w_diff_nxt, w_ext_diff;
    logic                  r_err, w_err_nxt;

    logic                  w_bit_ready;
    logic                  w_take;
    logic                  w_dec_done;
    logic                  w_dec_err;
    logic [3:0]            w_dec_size;

    assign w_mag_shift = {r_mag[MAX_SIZE-2:0], bus.bit_in};
    // Table choice is frozen once the first bit of a symbol is in.
    assign w_tsel      = (r_len == 4'd0) ? (bus.lumenb ? LUMA : CHROMA) : r_tsel;
    assign w_bit_ready = (r_state != S_DONE) &&
                         ((r_state == S_CODE && r_len == 4'd0) ?
                          (bus.lumenb | bus.chromenb_u | bus.chromenb_v) : 1'b1);
    assign w_take      = bus.bit_valid & w_bit_ready;

    dcdiff_extend #(
        .DIFF_W   (DIFF_W),
        .MAX_SIZE (MAX_SIZE)
    ) u_extend (
        .size (r_size),
        .mag  (w_mag_shift),
        .diff (w_ext_diff)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_CODE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_tsel_nxt    = r_tsel;
        w_len_nxt     = r_len;
        w_allones_nxt = r_allones;
        w_code_nxt    = r_code;
        w_ext_nxt     = r_ext;
        w_mag_nxt     = r_mag;
        w_size_nxt    = r_size;
        w_diff_nxt    = r_diff;
        w_err_nxt     = r_err;
        w_dec_done    = 1'b0;
        w_dec_err     = 1'b0;
        w_dec_size    = 4'd0;

        // Prefix match including the bit currently on bit_in.
        if (w_tsel == LUMA) begin
            if (r_allones) begin
                if (bus.bit_in) begin
                    w_dec_err = (r_len == 4'(c_LUMA_MAX_ONES));
                end else if (r_len >= 4'd2) begin
                    w_dec_done = 1'b1;
                    w_dec_size = r_len + 4'(c_LUMA_LONG_OFS);
                end
            end else if (r_len == 4'd1) begin
                w_dec_done = ~bus.bit_in;
            end else begin
                // 3-bit codes 010..110 map to size = code - 1.
                w_dec_done = 1'b1;
                w_dec_size = {1'b0, r_code, bus.bit_in} - 4'd1;
            end
        end else begin
            if (r_allones) begin
                if (bus.bit_in) begin
                    w_dec_err = (r_len == 4'(c_CHROMA_MAX_ONES));
                end else if (r_len >= 4'd1) begin
                    w_dec_done = 1'b1;
                    w_dec_size = r_len + 4'(c_CHROMA_LONG_OFS);
                end
            end else begin
                w_dec_done = 1'b1;
                w_dec_size = {3'd0, bus.bit_in};
            end
        end

        case (r_state)
            S_CODE: begin
                if (w_take) begin
                    w_tsel_nxt    = w_tsel;
                    w_len_nxt     = r_len + 4'd1;
                    w_code_nxt    = {r_code[0], bus.bit_in};
                    w_allones_nxt = r_allones & bus.bit_in;
                    if (w_dec_err) begin
                        w_state_nxt = S_DONE;
                        w_err_nxt   = 1'b1;
                        w_size_nxt  = 4'd0;
                        w_diff_nxt  = '0;
                    end else if (w_dec_done) begin
                        w_err_nxt  = 1'b0;
                        w_size_nxt = w_dec_size;
                        if (w_dec_size == 4'd0) begin
                            w_state_nxt = S_DONE;
                            w_diff_nxt  = '0;
                        end else begin
                            w_state_nxt = S_EXTRA;
                            w_ext_nxt   = w_dec_size;
                            w_mag_nxt   = '0;
                        end
                    end
                end
            end
            S_EXTRA: begin
                if (w_take) begin
                    w_mag_nxt = w_mag_shift;
                    w_ext_nxt = r_ext - 4'd1;
                    if (r_ext == 4'd1) begin
                        w_state_nxt = S_DONE;
                        w_diff_nxt  = w_ext_diff;
                    end
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt   = S_CODE;
                    w_len_nxt     = 4'd0;
                    w_allones_nxt = 1'b1;
                    w_code_nxt    = 2'd0;
                end
            end
            default: w_state_nxt = S_CODE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tsel    <= LUMA;
            r_len     <= 4'd0;
            r_allones <= 1'b1;
            r_code    <= 2'd0;
            r_ext     <= 4'd0;
            r_mag     <= '0;
            r_size    <= 4'd0;
            r_diff    <= '0;
            r_err     <= 1'b0;
        end else begin
            r_tsel    <= w_tsel_nxt;
            r_len     <= w_len_nxt;
            r_allones <= w_allones_nxt;
            r_code    <= w_code_nxt;
            r_ext     <= w_ext_nxt;
            r_mag     <= w_mag_nxt;
            r_size    <= w_size_nxt;
            r_diff    <= w_diff_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign bus.bit_ready = w_bit_ready;
    assign bus.size      = r_size;
    assign bus.diff      = r_diff;
    assign bus.err       = r_err;
    assign bus.out_valid = (r_state == S_DONE);

endmodule
`default_nettype wire
